// File: rtl/cps_video_conditioner_if.sv
// Pixel/sync bundle between the capture side and the video frontend.
interface cps_video_conditioner_if;
    logic [4:0]  R_i;
    logic [4:0]  G_i;
    logic [4:0]  B_i;
    logic        HSYNC_i;
    logic        VSYNC_i;
    logic [4:0]  R_o;
    logic [4:0]  G_o;
    logic [4:0]  B_o;
    logic        HSYNC_o;
    logic        VSYNC_o;
    logic        hpol_o;
    logic        vpol_o;
    logic [11:0] h_total_o;
    logic [10:0] v_total_o;
    logic        lock_o;

    modport master (
        output R_i, G_i, B_i, HSYNC_i, VSYNC_i,
        input  R_o, G_o, B_o, HSYNC_o, VSYNC_o, hpol_o, vpol_o,
               h_total_o, v_total_o, lock_o
    );

    modport slave (
        input  R_i, G_i, B_i, HSYNC_i, VSYNC_i,
        output R_o, G_o, B_o, HSYNC_o, VSYNC_o, hpol_o, vpol_o,
               h_total_o, v_total_o, lock_o
    );
endinterface

// File: rtl/cps_video_conditioner.sv
// Sync glitch filter, optional polarity normalisation, pixel delay alignment
// and line/frame timing measurement with line lock detection.
// Optional feature: define CPS_SYNC_POLDET_EN to enable sync polarity
// detection and normalisation to active-low.
module cps_video_conditioner #(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned LOCK_LINES = 8
) (
    input logic                    PCLK_i,
    input logic                    reset_n,
    cps_video_conditioner_if.slave vid
);
    // Input register plus filter plus output register give FILTER_LEN+1
    // cycles of sync latency, so pixels need one more stage than that count.
    localparam int unsigned PIPE_LEN = FILTER_LEN + 2;
    localparam logic [2:0]  RUN_LAST = 3'(FILTER_LEN - 1);
    localparam logic [3:0]  LOCK_MAX = 4'(LOCK_LINES);

    logic [1:0]  sync_q;          // {vsync, hsync}
    logic [1:0]  filt;
    logic [2:0]  run [2];
    logic [14:0] pix_q [PIPE_LEN];
    logic        hpol, vpol;
    logic        hs_o, vs_o, hs_o_d, vs_o_d;
    logic        h_lead, v_lead;
    logic [11:0] hcnt, h_len, h_total;
    logic [10:0] vcnt, v_len, v_total;
    logic        h_seen, v_seen;
    logic [3:0]  lock_cnt;

    // Register raw syncs and toggle each filter after FILTER_LEN differing samples
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            sync_q <= '1;
            filt   <= '1;
            for (int unsigned i = 0; i < 2; i++) run[i] <= '0;
        end else begin
            sync_q <= {vid.VSYNC_i, vid.HSYNC_i};
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_q[i] != filt[i]) begin
                    if (run[i] == RUN_LAST) begin
                        filt[i] <= ~filt[i];
                        run[i]  <= '0;
                    end else begin
                        run[i] <= run[i] + 3'd1;
                    end
                end else begin
                    run[i] <= '0;
                end
            end
        end
    end

    // Pixel delay line matching the sync path latency
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIPE_LEN; i++) pix_q[i] <= '0;
        end else begin
            pix_q[0] <= {vid.R_i, vid.G_i, vid.B_i};
            for (int unsigned i = 1; i < PIPE_LEN; i++) pix_q[i] <= pix_q[i - 1];
        end
    end

`ifdef CPS_SYNC_POLDET_EN
    logic [11:0] h_hi, h_lo;
    logic [10:0] v_hi, v_lo;
    logic [1:0]  filt_d;

    // Decide polarity at each filtered rising edge from the shorter level of the last period
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            h_hi   <= '0;
            h_lo   <= '0;
            v_hi   <= '0;
            v_lo   <= '0;
            hpol   <= 1'b0;
            vpol   <= 1'b0;
            filt_d <= '1;
        end else begin
            filt_d <= filt;
            if (filt[0] && !filt_d[0]) begin
                hpol <= (h_hi < h_lo);
                h_hi <= '0;
                h_lo <= '0;
            end else if (filt[0]) begin
                if (h_hi != '1) h_hi <= h_hi + 12'd1;
            end else begin
                if (h_lo != '1) h_lo <= h_lo + 12'd1;
            end
            if (filt[1] && !filt_d[1]) begin
                vpol <= (v_hi < v_lo);
                v_hi <= '0;
                v_lo <= '0;
            end else if (h_lead) begin
                if (filt[1]) begin
                    if (v_hi != '1) v_hi <= v_hi + 11'd1;
                end else begin
                    if (v_lo != '1) v_lo <= v_lo + 11'd1;
                end
            end
        end
    end
`else
    assign hpol = 1'b0;
    assign vpol = 1'b0;
`endif

    // Normalised sync outputs and one-cycle history for leading-edge detection
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            hs_o   <= 1'b1;
            vs_o   <= 1'b1;
            hs_o_d <= 1'b1;
            vs_o_d <= 1'b1;
        end else begin
            hs_o   <= filt[0] ^ hpol;
            vs_o   <= filt[1] ^ vpol;
            hs_o_d <= hs_o;
            vs_o_d <= vs_o;
        end
    end

    assign h_lead = hs_o_d & ~hs_o;
    assign v_lead = vs_o_d & ~vs_o;
    assign h_len  = (hcnt == '1) ? hcnt : hcnt + 12'd1;
    // A line ending on the same edge as the frame is counted into that frame.
    assign v_len  = (vcnt == '1) ? vcnt : vcnt + {10'd0, h_lead};

    // Line length measurement and lock counting; first edge after reset only arms
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            hcnt     <= '0;
            h_total  <= '0;
            h_seen   <= 1'b0;
            lock_cnt <= '0;
        end else if (h_lead) begin
            hcnt   <= '0;
            h_seen <= 1'b1;
            if (h_seen) begin
                h_total <= h_len;
                if (h_len == h_total && h_len != '1) begin
                    if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 4'd1;
                end else begin
                    lock_cnt <= '0;
                end
            end
        end else begin
            hcnt <= h_len;
        end
    end

    // Frame length measurement in lines
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            vcnt    <= '0;
            v_total <= '0;
            v_seen  <= 1'b0;
        end else if (v_lead) begin
            vcnt   <= '0;
            v_seen <= 1'b1;
            if (v_seen) v_total <= v_len;
        end else begin
            vcnt <= v_len;
        end
    end

    assign vid.R_o       = pix_q[PIPE_LEN - 1][14:10];
    assign vid.G_o       = pix_q[PIPE_LEN - 1][9:5];
    assign vid.B_o       = pix_q[PIPE_LEN - 1][4:0];
    assign vid.HSYNC_o   = hs_o;
    assign vid.VSYNC_o   = vs_o;
    assign vid.hpol_o    = hpol;
    assign vid.vpol_o    = vpol;
    assign vid.h_total_o = h_total;
    assign vid.v_total_o = v_total;
    assign vid.lock_o    = (lock_cnt == LOCK_MAX);
endmodule

// File: doc/cps_video_conditioner.md
CPS_VIDEO_CONDITIONER -- requirements
Module: cps_video_conditioner

Interface
REQ-001 Parameter FILTER_LEN, default 3: consecutive equal samples required before a filtered sync changes state; legal range 1-7.
REQ-002 Parameter LOCK_LINES, default 8: consecutive equal line lengths required to assert lock_o; legal range 2-15.
REQ-003 Port PCLK_i, input, 1: sole clock, all logic on rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Ports R_i/G_i/B_i, input, 5 each: latched capture pixel data.
REQ-006 Ports HSYNC_i/VSYNC_i, input, 1 each: raw syncs of unknown polarity.
REQ-007 Ports R_o/G_o/B_o, output, 5 each: delay-aligned pixel data to the frontend.
REQ-008 Ports HSYNC_o/VSYNC_o, output, 1 each: filtered syncs, normalized active-low.
REQ-009 Ports hpol_o/vpol_o, output, 1 each: detected input polarity, 1 = active-high.
REQ-010 Port h_total_o, output, 12: PCLK_i cycles per line.
REQ-011 Port v_total_o, output, 11: lines per frame.
REQ-012 Port lock_o, output, 1: line timing stable.

Function
REQ-013 Each filter holds a state and a run counter; output toggles only after FILTER_LEN consecutive samples differing from the current state; shorter glitches are discarded.
REQ-014 Filtered sync changes exactly FILTER_LEN+1 cycles after a clean input edge; R/G/B delayed FILTER_LEN+1 cycles so pixel/sync alignment is preserved.
REQ-015 HSYNC_o = filtered_hs XOR hpol_o; VSYNC_o = filtered_vs XOR vpol_o.
REQ-016 H polarity: 12-bit saturating hi/lo cycle counters on filtered_hs; at each filtered_hs rising edge, hpol_o <= (hi_cnt < lo_cnt), both counters clear.
REQ-017 V polarity: same scheme on filtered_vs counting lines (HSYNC_o leading edges) instead of cycles; 11-bit saturating.
REQ-018 Polarity change may yield one spurious edge on the normalized sync; no other suppression.
REQ-019 Leading edge = falling edge of normalized sync, detected one cycle after it appears.
REQ-020 h_total_o loads cycles between consecutive HSYNC_o leading edges; counter saturates at 4095, and a saturated value is loaded as 4095.
REQ-021 v_total_o loads lines between consecutive VSYNC_o leading edges; saturates at 2047.
REQ-022 Lock counter: at each H leading edge, increment (saturating at LOCK_LINES) if new length equals previous and is not 4095, else clear to 0.
REQ-023 lock_o = 1 iff lock counter == LOCK_LINES; deasserts on the first mismatching line.
REQ-024 Simultaneous H and V leading edges: line counted into the ending frame before v_total_o loads; new frame starts at 0.

Reset
REQ-025 While reset_n = 0 at a rising edge: R/G/B_o = 0, HSYNC_o = VSYNC_o = 1, hpol_o = vpol_o = 0, h_total_o = v_total_o = 0, lock_o = 0; all counters, filter states (= 1) and delay lines clear.
REQ-026 Reset mid-line takes effect in that cycle; first h_total_o update after release requires two leading edges.

Configuration
REQ-027 Macro CPS_SYNC_POLDET_EN: when defined, REQ-015 to REQ-018 apply.
REQ-028 When undefined: polarity counters absent, hpol_o = vpol_o = 0 constant, HSYNC_o/VSYNC_o = filtered input unmodified; all other behaviour unchanged.

Verification
REQ-029 FILTER_LEN=3, clean HSYNC_i fall at cycle 100 -> HSYNC_o falls at cycle 104; R_i at cycle 100 appears on R_o at cycle 104.
REQ-030 2-cycle high glitch on low HSYNC_i -> HSYNC_o unchanged; 3-cycle pulse -> HSYNC_o toggles.
REQ-031 With CPS_SYNC_POLDET_EN, active-high hsync (36 hi / 476 lo, 512-cycle line) -> hpol_o = 1 after second rising edge, HSYNC_o active-low, h_total_o = 512.
REQ-032 Twelve 512-cycle lines then one 513-cycle line -> lock_o rises at 8th equal comparison, falls at the 513 edge, h_total_o = 513.
REQ-033 262-line frame, active-low vsync 3 lines -> v_total_o = 262, vpol_o = 0; HSYNC_i held constant 5000 cycles -> h_total_o = 4095, lock_o = 0.
REQ-034 reset_n low for one cycle mid-line -> all outputs at REQ-025 values next cycle; without macro, active-high input passes uninverted with hpol_o = 0.
